// File: rtl/lsu_agu_pkg.sv
// Shared definitions for the load/store address generation unit.
// Holds default widths, FSM state encoding, access-size and exception codes.
package lsu_agu_pkg;

  localparam int unsigned DTCM_ADDR_WIDTH = 16;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned ITAG_WIDTH      = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StIssue   = 2'b01,
    StWaitRsp = 2'b10,
    StDone    = 2'b11
  } agu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam logic [1:0] EXCP_NONE     = 2'b00;
  localparam logic [1:0] EXCP_MISALIGN = 2'b01;
  localparam logic [1:0] EXCP_ACCFLT   = 2'b10;

endpackage

// File: rtl/lsu_agu_if.sv
// Bundle of the AGU's dispatch, lsu_ctrl command/response and completion channels.
// slave  : view used by lsu_agu
// master : view used by whatever surrounds it (dispatch, lsu_ctrl, writeback)
interface lsu_agu_if
  import lsu_agu_pkg::*;
#(
  parameter int unsigned AW = DTCM_ADDR_WIDTH,
  parameter int unsigned DW = XLEN,
  parameter int unsigned TW = ITAG_WIDTH
) ();

  // Dispatch
  logic          agu_i_valid;
  logic          agu_i_ready;
  logic          agu_i_load;
  logic [1:0]    agu_i_size;
  logic          agu_i_usign;
  logic [DW-1:0] agu_i_rs1;
  logic [DW-1:0] agu_i_imm;
  logic [DW-1:0] agu_i_rs2;
  logic [TW-1:0] agu_i_itag;

  // Command to lsu_ctrl
  logic            agu_cmd_valid;
  logic            agu_cmd_ready;
  logic            agu_cmd_read;
  logic [AW-1:0]   agu_cmd_addr;
  logic [DW-1:0]   agu_cmd_wdata;
  logic [DW/8-1:0] agu_cmd_wmask;
  logic [TW-1:0]   agu_cmd_itag;

  // Response from lsu_ctrl
  logic          agu_rsp_valid;
  logic          agu_rsp_ready;
  logic [DW-1:0] agu_rsp_rdata;

  // Completion
  logic          agu_o_valid;
  logic          agu_o_ready;
  logic [DW-1:0] agu_o_data;
  logic [TW-1:0] agu_o_itag;
  logic          agu_o_excp;
  logic [1:0]    agu_o_excp_code;

  modport slave (
    input  agu_i_valid, agu_i_load, agu_i_size, agu_i_usign, agu_i_rs1, agu_i_imm,
    input  agu_i_rs2, agu_i_itag, agu_cmd_ready, agu_rsp_valid, agu_rsp_rdata, agu_o_ready,
    output agu_i_ready, agu_cmd_valid, agu_cmd_read, agu_cmd_addr, agu_cmd_wdata,
    output agu_cmd_wmask, agu_cmd_itag, agu_rsp_ready, agu_o_valid, agu_o_data, agu_o_itag,
    output agu_o_excp, agu_o_excp_code
  );

  modport master (
    output agu_i_valid, agu_i_load, agu_i_size, agu_i_usign, agu_i_rs1, agu_i_imm,
    output agu_i_rs2, agu_i_itag, agu_cmd_ready, agu_rsp_valid, agu_rsp_rdata, agu_o_ready,
    input  agu_i_ready, agu_cmd_valid, agu_cmd_read, agu_cmd_addr, agu_cmd_wdata,
    input  agu_cmd_wmask, agu_cmd_itag, agu_rsp_ready, agu_o_valid, agu_o_data, agu_o_itag,
    input  agu_o_excp, agu_o_excp_code
  );

endinterface

// File: rtl/lsu_ld_align.sv
// Load data aligner: shifts the DTCM word down by the byte offset and
// sign/zero-extends byte and half loads. Purely combinational.
//   rdata : raw word from DTCM
//   off   : byte offset of the access within the word
//   size  : access size (SZ_B/SZ_H/SZ_W)
//   usign : zero-extend instead of sign-extend
//   data  : aligned, extended result
module lsu_ld_align
  import lsu_agu_pkg::*;
#(
  parameter int unsigned DW = XLEN
) (
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    off,
  input  logic [1:0]    size,
  input  logic          usign,
  output logic [DW-1:0] data
);

  logic [DW-1:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    data = rdata;
    case (size)
      SZ_B:    data = {{(DW-8){~usign & sh[7]}}, sh[7:0]};
      SZ_H:    data = {{(DW-16){~usign & sh[15]}}, sh[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_agu.sv
// Load/store address generation unit sitting in front of lsu_ctrl.
// Accepts one memory op, computes rs1+imm, checks alignment and DTCM range,
// issues a word-aligned command, waits for the response and presents an
// aligned/extended completion. One operation in flight at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dispatch (agu_i_*), command (agu_cmd_*), response (agu_rsp_*)
//                and completion (agu_o_*) channels
module lsu_agu
  import lsu_agu_pkg::*;
#(
  parameter int unsigned AW = DTCM_ADDR_WIDTH,
  parameter int unsigned DW = XLEN,
  parameter int unsigned TW = ITAG_WIDTH
) (
  input logic     clk,
  input logic     rst_n,
  lsu_agu_if.slave bus
);

  agu_state_e state_q, state_d;

  logic [AW-1:0]   addr_q;
  logic            load_q;
  logic [1:0]      size_q;
  logic            usign_q;
  logic [TW-1:0]   itag_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wmask_q;
  logic [DW-1:0]   data_q;
  logic            excp_q;
  logic [1:0]      code_q;

  logic [DW-1:0]   sum;
  logic [1:0]      off;
  logic            misalign;
  logic            acc_fault;
  logic [DW-1:0]   wdata_d;
  logic [DW/8-1:0] wmask_d;
  logic [DW-1:0]   ld_data;

  logic accept, rsp_hs;
  logic i_ready, cmd_valid, rsp_ready, o_valid;

  // Address arithmetic wraps; any bit above the DTCM window is a fault.
  assign sum       = bus.agu_i_rs1 + bus.agu_i_imm;
  assign off       = sum[1:0];
  assign misalign  = (bus.agu_i_size == SZ_X) ||
                     (bus.agu_i_size == SZ_H && off[0]) ||
                     (bus.agu_i_size == SZ_W && off != 2'b00);
  assign acc_fault = |sum[DW-1:AW];

  // Store lanes: replicate the data, enable only the addressed bytes.
  always_comb begin
    wdata_d = '0;
    wmask_d = '0;
    if (!bus.agu_i_load) begin
      case (bus.agu_i_size)
        SZ_B: begin
          wdata_d = {4{bus.agu_i_rs2[7:0]}};
          wmask_d = 4'b0001 << off;
        end
        SZ_H: begin
          wdata_d = {2{bus.agu_i_rs2[15:0]}};
          wmask_d = 4'b0011 << off;
        end
        SZ_W: begin
          wdata_d = bus.agu_i_rs2;
          wmask_d = '1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    rsp_hs    = 1'b0;
    i_ready   = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    o_valid   = 1'b0;
    unique case (state_q)
      StIdle: begin
        i_ready = 1'b1;
        if (bus.agu_i_valid) begin
          accept  = 1'b1;
          state_d = (misalign || acc_fault) ? StDone : StIssue;
        end
      end
      StIssue: begin
        cmd_valid = 1'b1;
        if (bus.agu_cmd_ready) state_d = StWaitRsp;
      end
      StWaitRsp: begin
        rsp_ready = 1'b1;
        if (bus.agu_rsp_valid) begin
          rsp_hs  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        o_valid = 1'b1;
        if (bus.agu_o_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  lsu_ld_align #(
    .DW (DW)
  ) u_ld_align (
    .rdata (bus.agu_rsp_rdata),
    .off   (addr_q[1:0]),
    .size  (size_q),
    .usign (usign_q),
    .data  (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      load_q  <= 1'b0;
      size_q  <= '0;
      usign_q <= 1'b0;
      itag_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      data_q  <= '0;
      excp_q  <= 1'b0;
      code_q  <= EXCP_NONE;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= sum[AW-1:0];
        load_q  <= bus.agu_i_load;
        size_q  <= bus.agu_i_size;
        usign_q <= bus.agu_i_usign;
        itag_q  <= bus.agu_i_itag;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
        // Cleared so exception completions and stores report zero data.
        data_q  <= '0;
        excp_q  <= misalign || acc_fault;
        code_q  <= misalign ? EXCP_MISALIGN : (acc_fault ? EXCP_ACCFLT : EXCP_NONE);
      end else if (rsp_hs) begin
        data_q <= load_q ? ld_data : '0;
      end
    end
  end

  assign bus.agu_i_ready     = i_ready;
  assign bus.agu_cmd_valid   = cmd_valid;
  assign bus.agu_cmd_read    = load_q;
  assign bus.agu_cmd_addr    = {addr_q[AW-1:2], 2'b00};
  assign bus.agu_cmd_wdata   = wdata_q;
  assign bus.agu_cmd_wmask   = wmask_q;
  assign bus.agu_cmd_itag    = itag_q;
  assign bus.agu_rsp_ready   = rsp_ready;
  assign bus.agu_o_valid     = o_valid;
  assign bus.agu_o_data      = data_q;
  assign bus.agu_o_itag      = itag_q;
  assign bus.agu_o_excp      = excp_q;
  assign bus.agu_o_excp_code = code_q;

endmodule

// File: tb/tb_lsu_agu.sv
// Directed self-checking bench for lsu_agu: loads, stores, exceptions,
// back-pressure and mid-operation reset.
module tb_lsu_agu;
  import lsu_agu_pkg::*;

  localparam int unsigned AW = DTCM_ADDR_WIDTH;
  localparam int unsigned DW = XLEN;
  localparam int unsigned TW = ITAG_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int failures = 0;

  lsu_agu_if #(.AW(AW), .DW(DW), .TW(TW)) bus ();

  lsu_agu #(.AW(AW), .DW(DW), .TW(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // The DTCM model only drives a response while the AGU is waiting for one.
  always @(negedge clk) begin
    if (rst_n && bus.agu_rsp_valid)
      check("rsp_valid_only_in_wait", 32'(bus.agu_rsp_ready), 32'd1);
  end

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic dispatch(input logic load, input logic [1:0] size, input logic usign,
                          input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [31:0] rs2, input logic [TW-1:0] itag);
    bus.agu_i_valid = 1'b1;
    bus.agu_i_load  = load;
    bus.agu_i_size  = size;
    bus.agu_i_usign = usign;
    bus.agu_i_rs1   = rs1;
    bus.agu_i_imm   = imm;
    bus.agu_i_rs2   = rs2;
    bus.agu_i_itag  = itag;
    check("i_ready_idle", 32'(bus.agu_i_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.agu_i_valid = 1'b0;
    bus.agu_i_rs1   = 32'hFFFF_FFFF;
    bus.agu_i_rs2   = 32'h0;
    @(negedge clk);
  endtask

  task automatic expect_cmd(input string tag, input logic [31:0] addr, input logic read,
                            input logic [31:0] wdata, input logic [3:0] wmask,
                            input logic [TW-1:0] itag);
    check({tag, "_cmd_valid"}, 32'(bus.agu_cmd_valid), 32'd1);
    check({tag, "_i_ready_busy"}, 32'(bus.agu_i_ready), 32'd0);
    check({tag, "_cmd_addr"}, 32'(bus.agu_cmd_addr), addr);
    check({tag, "_cmd_read"}, 32'(bus.agu_cmd_read), 32'(read));
    check({tag, "_cmd_wdata"}, bus.agu_cmd_wdata, wdata);
    check({tag, "_cmd_wmask"}, 32'(bus.agu_cmd_wmask), 32'(wmask));
    check({tag, "_cmd_itag"}, 32'(bus.agu_cmd_itag), 32'(itag));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic respond(input string tag, input logic [31:0] rdata);
    check({tag, "_rsp_ready"}, 32'(bus.agu_rsp_ready), 32'd1);
    check({tag, "_cmd_dropped"}, 32'(bus.agu_cmd_valid), 32'd0);
    bus.agu_rsp_valid = 1'b1;
    bus.agu_rsp_rdata = rdata;
    @(posedge clk);
    #1;
    bus.agu_rsp_valid = 1'b0;
    bus.agu_rsp_rdata = 32'h0;
    @(negedge clk);
  endtask

  // Checks the completion, takes it (agu_o_ready assumed 1), then checks idle.
  task automatic expect_done(input string tag, input logic [31:0] data,
                             input logic [TW-1:0] itag, input logic excp,
                             input logic [1:0] code);
    check({tag, "_o_valid"}, 32'(bus.agu_o_valid), 32'd1);
    check({tag, "_o_data"}, bus.agu_o_data, data);
    check({tag, "_o_itag"}, 32'(bus.agu_o_itag), 32'(itag));
    check({tag, "_o_excp"}, 32'(bus.agu_o_excp), 32'(excp));
    check({tag, "_o_code"}, 32'(bus.agu_o_excp_code), 32'(code));
    check({tag, "_no_cmd"}, 32'(bus.agu_cmd_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_i_ready_after"}, 32'(bus.agu_i_ready), 32'd1);
    check({tag, "_o_valid_after"}, 32'(bus.agu_o_valid), 32'd0);
  endtask

  initial begin
    bus.agu_i_valid   = 1'b0;
    bus.agu_i_load    = 1'b0;
    bus.agu_i_size    = 2'b00;
    bus.agu_i_usign   = 1'b0;
    bus.agu_i_rs1     = 32'h0;
    bus.agu_i_imm     = 32'h0;
    bus.agu_i_rs2     = 32'h0;
    bus.agu_i_itag    = '0;
    bus.agu_cmd_ready = 1'b1;
    bus.agu_rsp_valid = 1'b0;
    bus.agu_rsp_rdata = 32'h0;
    bus.agu_o_ready   = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_i_ready", 32'(bus.agu_i_ready), 32'd1);
    check("rst_cmd_valid", 32'(bus.agu_cmd_valid), 32'd0);
    check("rst_cmd_read", 32'(bus.agu_cmd_read), 32'd0);
    check("rst_cmd_addr", 32'(bus.agu_cmd_addr), 32'd0);
    check("rst_cmd_wmask", 32'(bus.agu_cmd_wmask), 32'd0);
    check("rst_rsp_ready", 32'(bus.agu_rsp_ready), 32'd0);
    check("rst_o_valid", 32'(bus.agu_o_valid), 32'd0);
    check("rst_o_data", bus.agu_o_data, 32'd0);
    check("rst_o_excp", 32'(bus.agu_o_excp), 32'd0);
    check("rst_o_code", 32'(bus.agu_o_excp_code), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load word 0x100+4
    dispatch(1'b1, SZ_W, 1'b0, 32'h100, 32'h4, 32'h5555_5555, 4'h1);
    expect_cmd("lw", 32'h104, 1'b1, 32'h0, 4'h0, 4'h1);
    respond("lw", 32'hDEAD_BEEF);
    expect_done("lw", 32'hDEAD_BEEF, 4'h1, 1'b0, EXCP_NONE);

    // Signed byte load at 0x203 (0x204 + -1 wraps)
    dispatch(1'b1, SZ_B, 1'b0, 32'h204, 32'hFFFF_FFFF, 32'h0, 4'h2);
    expect_cmd("lb", 32'h200, 1'b1, 32'h0, 4'h0, 4'h2);
    respond("lb", 32'h8000_0000);
    expect_done("lb", 32'hFFFF_FF80, 4'h2, 1'b0, EXCP_NONE);

    // Unsigned byte load at 0x203
    dispatch(1'b1, SZ_B, 1'b1, 32'h200, 32'h3, 32'h0, 4'h3);
    expect_cmd("lbu", 32'h200, 1'b1, 32'h0, 4'h0, 4'h3);
    respond("lbu", 32'h8000_0000);
    expect_done("lbu", 32'h0000_0080, 4'h3, 1'b0, EXCP_NONE);

    // Signed half load at 0x206
    dispatch(1'b1, SZ_H, 1'b0, 32'h206, 32'h0, 32'h0, 4'h4);
    expect_cmd("lh", 32'h204, 1'b1, 32'h0, 4'h0, 4'h4);
    respond("lh", 32'h8001_7FFF);
    expect_done("lh", 32'hFFFF_8001, 4'h4, 1'b0, EXCP_NONE);

    // Store half at 0x12
    dispatch(1'b0, SZ_H, 1'b0, 32'h10, 32'h2, 32'h0000_ABCD, 4'h5);
    expect_cmd("sh", 32'h10, 1'b0, 32'hABCD_ABCD, 4'b1100, 4'h5);
    respond("sh", 32'h1234_5678);
    expect_done("sh", 32'h0, 4'h5, 1'b0, EXCP_NONE);

    // Store byte at 0x21
    dispatch(1'b0, SZ_B, 1'b0, 32'h20, 32'h1, 32'h1234_565A, 4'h6);
    expect_cmd("sb", 32'h20, 1'b0, 32'h5A5A_5A5A, 4'b0010, 4'h6);
    respond("sb", 32'hFFFF_FFFF);
    expect_done("sb", 32'h0, 4'h6, 1'b0, EXCP_NONE);

    // Store word at 0x30
    dispatch(1'b0, SZ_W, 1'b0, 32'h30, 32'h0, 32'hCAFE_F00D, 4'h7);
    expect_cmd("sw", 32'h30, 1'b0, 32'hCAFE_F00D, 4'b1111, 4'h7);
    respond("sw", 32'h0);
    expect_done("sw", 32'h0, 4'h7, 1'b0, EXCP_NONE);

    // Exceptions complete one cycle after acceptance without a command
    dispatch(1'b1, SZ_W, 1'b0, 32'h100, 32'h2, 32'h0, 4'h8);
    expect_done("mis_w", 32'h0, 4'h8, 1'b1, EXCP_MISALIGN);
    dispatch(1'b1, SZ_W, 1'b0, 32'h1 << AW, 32'h0, 32'h0, 4'h9);
    expect_done("accflt", 32'h0, 4'h9, 1'b1, EXCP_ACCFLT);
    dispatch(1'b0, SZ_X, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 4'hA);
    expect_done("sz_ill", 32'h0, 4'hA, 1'b1, EXCP_MISALIGN);
    dispatch(1'b1, SZ_H, 1'b0, (32'h1 << AW) + 32'h1, 32'h0, 32'h0, 4'hB);
    expect_done("mis_prio", 32'h0, 4'hB, 1'b1, EXCP_MISALIGN);

    // Back-pressure on command and completion
    bus.agu_cmd_ready = 1'b0;
    dispatch(1'b1, SZ_W, 1'b0, 32'h3C, 32'h4, 32'h0, 4'hC);
    for (int i = 0; i < 3; i++) begin
      check("bp_cmd_valid", 32'(bus.agu_cmd_valid), 32'd1);
      check("bp_cmd_addr", 32'(bus.agu_cmd_addr), 32'h40);
      check("bp_cmd_read", 32'(bus.agu_cmd_read), 32'd1);
      check("bp_cmd_itag", 32'(bus.agu_cmd_itag), 32'hC);
      check("bp_i_ready", 32'(bus.agu_i_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.agu_cmd_ready = 1'b1;
    expect_cmd("bp", 32'h40, 1'b1, 32'h0, 4'h0, 4'hC);
    respond("bp", 32'h1357_9BDF);
    bus.agu_o_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("bp_o_valid_held", 32'(bus.agu_o_valid), 32'd1);
      check("bp_o_data_held", bus.agu_o_data, 32'h1357_9BDF);
      check("bp_i_ready_held", 32'(bus.agu_i_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.agu_o_ready = 1'b1;
    expect_done("bp", 32'h1357_9BDF, 4'hC, 1'b0, EXCP_NONE);

    // Reset while waiting for the response
    dispatch(1'b1, SZ_W, 1'b0, 32'h80, 32'h0, 32'h0, 4'hD);
    expect_cmd("rstw", 32'h80, 1'b1, 32'h0, 4'h0, 4'hD);
    check("rstw_rsp_ready", 32'(bus.agu_rsp_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_i_ready", 32'(bus.agu_i_ready), 32'd1);
    check("rstw_cmd_valid", 32'(bus.agu_cmd_valid), 32'd0);
    check("rstw_cmd_addr", 32'(bus.agu_cmd_addr), 32'd0);
    check("rstw_cmd_read", 32'(bus.agu_cmd_read), 32'd0);
    check("rstw_rsp_ready", 32'(bus.agu_rsp_ready), 32'd0);
    check("rstw_o_valid", 32'(bus.agu_o_valid), 32'd0);
    check("rstw_o_itag", 32'(bus.agu_o_itag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_idle_after", 32'(bus.agu_i_ready), 32'd1);
    check("rstw_o_valid_after", 32'(bus.agu_o_valid), 32'd0);
    dispatch(1'b1, SZ_W, 1'b0, 32'h84, 32'h0, 32'h0, 4'hE);
    expect_cmd("post", 32'h84, 1'b1, 32'h0, 4'h0, 4'hE);
    respond("post", 32'h0BAD_F00D);
    expect_done("post", 32'h0BAD_F00D, 4'hE, 1'b0, EXCP_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_agu.md
Name: lsu_agu

Overview:
- Address generation unit directly upstream of lsu_ctrl.
- Accepts one load/store from the execute dispatch, computes the byte address as rs1+imm, and checks alignment and DTCM range.
- Drives lsu_ctrl's agu_cmd_* interface with a word-aligned address, replicated store data and a byte mask.
- Waits for the DTCM response, then shifts and extends load data and presents a completion (data or exception) to commit/writeback. One operation is in flight at a time.

Parameters:
- AW, `DTCM_ADDR_WIDTH, DTCM byte-address width.
- DW, `XLEN, data width; fixed at 32 in this design.
- TW, `ITAG_WIDTH, instruction tag width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- agu_i_valid  in  1  dispatch valid
- agu_i_ready  out  1  dispatch ready
- agu_i_load  in  1  op is a load (else store)
- agu_i_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- agu_i_usign  in  1  zero-extend load
- agu_i_rs1  in  DW  base register
- agu_i_imm  in  DW  sign-extended offset
- agu_i_rs2  in  DW  store data
- agu_i_itag  in  TW  instruction tag
- agu_cmd_valid  out  1  command to lsu_ctrl
- agu_cmd_ready  in  1
- agu_cmd_read  out  1
- agu_cmd_addr  out  AW
- agu_cmd_wdata  out  DW
- agu_cmd_wmask  out  DW/8
- agu_cmd_itag  out  TW
- agu_rsp_valid  in  1  response from lsu_ctrl
- agu_rsp_ready  out  1
- agu_rsp_rdata  in  DW
- agu_o_valid  out  1  completion valid
- agu_o_ready  in  1
- agu_o_data  out  DW  aligned, extended load data; 0 for stores and exceptions
- agu_o_itag  out  TW
- agu_o_excp  out  1
- agu_o_excp_code  out  2  01=misaligned, 10=access fault

Behaviour:
- FSM: IDLE, ISSUE, WAIT_RSP, DONE. On reset, state=IDLE and every registered field is 0. All outputs reset to 0 except agu_i_ready, which is 1.
- agu_i_ready = (state==IDLE). On the dispatch handshake, register:
  - addr = rs1+imm, mod 2^32, carry discarded
  - load, size, usign, itag, off = addr[1:0]
  - wdata, wmask (below)
- Exception check, done at accept:
  - misaligned if size==11, or half with addr[0]=1, or word with addr[1:0]!=0
  - access fault if addr[DW-1:AW] != 0
  - misaligned takes priority over access fault
- Accept with exception: go to DONE with excp=1 and the code set. No command is issued.
- Accept with no exception: go to ISSUE.
- ISSUE:
  - agu_cmd_valid=1; fields held stable until the handshake
  - agu_cmd_read=load
  - agu_cmd_addr = {addr[AW-1:2], 2'b00}
  - on agu_cmd_ready, go to WAIT_RSP
- Store data and mask:
  - byte: wdata={4{rs2[7:0]}}, wmask=0001<<off
  - half: wdata={2{rs2[15:0]}}, wmask=0011<<off
  - word: wdata=rs2, wmask=1111
  - load: wmask=0000, wdata=0
- WAIT_RSP: agu_rsp_ready=1, and it is 0 in every other state. DTCM answers every command, loads and stores alike.
  - On agu_rsp_valid: sh = rdata >> (8*off). Byte loads take sh[7:0] and half loads take sh[15:0], each sign- or zero-extended per usign. Word loads take rdata. Stores get 0.
  - Capture the result into the data register and go to DONE.
- DONE: agu_o_valid=1; data, itag, excp and code held stable until agu_o_ready, then go to IDLE.
- Latency with no stalls: accept at cycle N, command at N+1, response at N+2, agu_o_valid at N+3, next accept at N+4. The exception path gives agu_o_valid at N+1.
- agu_rsp_valid outside WAIT_RSP is ignored; the bench asserts it never happens.
- Reset asserted mid-operation: immediately returns to IDLE, drops the in-flight command and completion, clears all outputs.
- All datapath registers load only on their state's handshake. No combinational path from agu_i_* to agu_cmd_*.

Decomposition:
- Shared defines: AGU state encodings, size encodings (SZ_B/SZ_H/SZ_W), exception codes (EXCP_MISALIGN/EXCP_ACCFLT).
- One sub-module: lsu_ld_align, purely combinational (rdata, off, size, usign -> aligned data).
- Store-mask generation stays inline.

Test Plan:
1. Load word: rs1=0x100, imm=0x4, rdata=0xDEADBEEF, all readies 1.
   -> cmd_addr=0x104, read=1, wmask=0; agu_o_data=0xDEADBEEF at N+3, excp=0.
2. Signed byte load: addr=0x203, rdata=0x80000000.
   -> data=0xFFFFFF80. With usign=1 -> 0x00000080.
3. Store half: addr=0x12, rs2=0x0000ABCD.
   -> wdata=0xABCDABCD, wmask=1100, read=0; completion data=0.
4. Misaligned word at addr=0x102; then word at 1<<AW.
   -> No cmd_valid; excp=1, code=01 at N+1. Second case gives code=10.
5. Back-pressure: cmd_ready=0 for 3 cycles, then agu_o_ready=0 for 2 cycles.
   -> cmd fields stable, agu_i_ready=0 throughout; completion held then released; agu_i_ready=1 the cycle after the o handshake.
6. Reset in WAIT_RSP: rst_n low for 1 cycle.
   -> state IDLE, all outputs 0, agu_i_ready=1 after release; next load completes normally.
